// File: rtl/mips_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | mips_ctrl_pkg: shared types/encodings for the multicycle MIPS controller |
// | Optional: MIPS_CTRL_LOGIC_IMM_EN adds andi/ori states.  Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
`ifdef MIPS_CTRL_LOGIC_IMM_EN
        , ANDIEX = 4'd12
        , ORIEX  = 4'd13
`endif
    } statetype;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_FUNCT = 3'd2,
        ALUOP_AND   = 3'd3,
        ALUOP_OR    = 3'd4
    } aluop_t;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_slt = 3'b111;

    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_aludec.sv
// +--------------------------------------------------------------------------+
// | mips_aludec: combinational ALU decoder (aluop, funct -> alucontrol)      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_aludec
    import mips_ctrl_pkg::*;
#(
    parameter int FN_W = 6
) (
    input  aluop_t          aluop,
    input  logic [FN_W-1:0] funct,
    output logic [2:0]      alucontrol
);

    always_comb begin
        alucontrol = c_alu_add;
        case (aluop)
            ALUOP_SUB: alucontrol = c_alu_sub;
            ALUOP_AND: alucontrol = c_alu_and;
            ALUOP_OR:  alucontrol = c_alu_or;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes quietly fall back to add.
                case (funct)
                    c_fn_add: alucontrol = c_alu_add;
                    c_fn_sub: alucontrol = c_alu_sub;
                    c_fn_and: alucontrol = c_alu_and;
                    c_fn_or:  alucontrol = c_alu_or;
                    c_fn_slt: alucontrol = c_alu_slt;
                    default:  alucontrol = c_alu_add;
                endcase
            end
            default: alucontrol = c_alu_add;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// +--------------------------------------------------------------------------+
// | mips_multicycle_ctrl: Moore FSM main control for the multicycle MIPS     |
// | Optional: MIPS_CTRL_LOGIC_IMM_EN (andi/ori, zeroext port).  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    output logic            iord,
    output logic            irwrite,
    output logic            memwrite,
    output logic            regwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [2:0]      alucontrol,
    output logic            pcen,
    output logic            illegal_op,
    output logic [3:0]      state_o
`ifdef MIPS_CTRL_LOGIC_IMM_EN
    , output logic          zeroext
`endif
);

    statetype r_state;
    statetype w_next_state;
    aluop_t   w_aluop;
    logic     w_illegal;
    logic     w_iord, w_irwrite, w_memwrite, w_regwrite, w_regdst, w_memtoreg;
    logic     w_alusrca, w_pcwrite, w_branch, w_zeroext;
    logic [1:0] w_alusrcb, w_pcsrc;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= FETCH;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: w_next_state = DECODE;
            DECODE: begin
                case (op)
                    c_op_lw, c_op_sw: w_next_state = MEMADR;
                    c_op_rtype:       w_next_state = RTYPEEX;
                    c_op_beq:         w_next_state = BEQEX;
                    c_op_addi:        w_next_state = ADDIEX;
                    c_op_j:           w_next_state = JEX;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
                    c_op_andi:        w_next_state = ANDIEX;
                    c_op_ori:         w_next_state = ORIEX;
`endif
                    default:          w_illegal    = 1'b1;
                endcase
            end
            MEMADR:  w_next_state = (op == c_op_sw) ? MEMWR : MEMRD;
            MEMRD:   w_next_state = MEMWB;
            RTYPEEX: w_next_state = RTYPEWB;
            ADDIEX:  w_next_state = ADDIWB;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            ANDIEX:  w_next_state = ADDIWB;
            ORIEX:   w_next_state = ADDIWB;
`endif
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = c_srcb_reg;
        w_pcsrc    = c_pc_alu;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_zeroext  = 1'b0;
        w_aluop    = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = c_srcb_four;
            end
            DECODE: w_alusrcb = c_srcb_immsh;
            MEMADR, ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_srcb_imm;
            end
            MEMRD: w_iord = 1'b1;
            MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
            end
            RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
            end
            BEQEX: begin
                w_alusrca = 1'b1;
                w_branch  = 1'b1;
                w_pcsrc   = c_pc_aluout;
                w_aluop   = ALUOP_SUB;
            end
            ADDIWB: w_regwrite = 1'b1;
            JEX: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = c_pc_jump;
            end
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            ANDIEX, ORIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_srcb_imm;
                w_zeroext = 1'b1;
                w_aluop   = (r_state == ANDIEX) ? ALUOP_AND : ALUOP_OR;
            end
`endif
            default: ;
        endcase
    end

    mips_aludec #(
        .FN_W (FN_W)
    ) u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Reset overrides the state decode so an aborted instruction never writes.
    assign iord       = rst & w_iord;
    assign irwrite    = rst & w_irwrite;
    assign memwrite   = rst & w_memwrite;
    assign regwrite   = rst & w_regwrite;
    assign regdst     = rst & w_regdst;
    assign memtoreg   = rst & w_memtoreg;
    assign alusrca    = rst & w_alusrca;
    assign alusrcb    = rst ? w_alusrcb : 2'b00;
    assign pcsrc      = rst ? w_pcsrc : 2'b00;
    assign pcen       = rst & (w_pcwrite | (w_branch & zero));
    assign illegal_op = rst & w_illegal;
    assign state_o    = r_state;

`ifdef MIPS_CTRL_LOGIC_IMM_EN
    assign zeroext = rst & w_zeroext;
`else
    logic w_unused;
    assign w_unused = w_zeroext;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mips_multicycle_ctrl: scoreboard bench for mips_multicycle_ctrl       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] ctl;
        logic [2:0]  alu;
        logic        chk_alu;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, illegal_op;
    logic [3:0] state_o;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
    logic       zeroext;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OP_W(6), .FN_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state_o    (state_o)
`ifdef MIPS_CTRL_LOGIC_IMM_EN
        , .zeroext  (zeroext)
`endif
    );

    wire logic [12:0] act_ctl;
    assign act_ctl = {iord, irwrite, memwrite, regwrite, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, pcen, illegal_op};

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for a given state, straight from the state table.
    function automatic exp_t mk(input logic [3:0] st, input logic [5:0] o,
                                input logic [5:0] f, input logic z, input logic r);
        exp_t e;
        logic io, ir, mw, rw, rd, mr, sa, pw, br, ill, legal;
        logic [1:0] sb, ps;
        logic [2:0] al;
        io = 0; ir = 0; mw = 0; rw = 0; rd = 0; mr = 0; sa = 0; pw = 0; br = 0; ill = 0;
        sb = 2'b00; ps = 2'b00; al = 3'b010;
        legal = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
`ifdef MIPS_CTRL_LOGIC_IMM_EN
        legal = legal || (o == ANDI) || (o == 6'b001101);
`endif
        case (st)
            4'd0:  begin ir = 1; pw = 1; sb = 2'b01; end
            4'd1:  begin sb = 2'b11; ill = !legal; end
            4'd2, 4'd9: begin sa = 1; sb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin rw = 1; mr = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; al = fn_alu(f); end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; br = 1; ps = 2'b01; al = 3'b110; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; ps = 2'b10; end
            4'd12: begin sa = 1; sb = 2'b10; al = 3'b000; end
            4'd13: begin sa = 1; sb = 2'b10; al = 3'b001; end
            default: ;
        endcase
        e.st      = st;
        e.ctl     = r ? {io, ir, mw, rw, rd, mr, sa, sb, ps, pw | (br & z), ill} : 13'd0;
        e.alu     = al;
        e.chk_alu = r;
        return e;
    endfunction

    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic r, input logic [3:0] st);
        @(negedge clk);
        op = o; funct = f; zero = z; rst = r;
        q.push_back(mk(st, o, f, z, r));
    endtask

    task automatic run_seq(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3, input int n);
        logic [3:0] seq [4];
        seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
        for (int i = 0; i < n; i++) cyc(o, f, z, 1'b1, seq[i]);
    endtask

    // Monitor: compares whatever the stimulus side queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (state_o !== e.st) begin
                    errors++;
                    $display("FAIL state: got %0d expected %0d at %0t", state_o, e.st, $time);
                end
                checks++;
                if (act_ctl !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl(st=%0d): got %b expected %b at %0t", e.st, act_ctl, e.ctl, $time);
                end
                if (e.chk_alu) begin
                    checks++;
                    if (alucontrol !== e.alu) begin
                        errors++;
                        $display("FAIL alucontrol(st=%0d): got %b expected %b at %0t",
                                 e.st, alucontrol, e.alu, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; op = LW; funct = 6'd0; zero = 1'b0;
        @(posedge clk);
        // Reset held two cycles, then release straight into the lw fetch.
        cyc(LW, 6'd0, 1'b0, 1'b0, 4'd0);
        cyc(LW, 6'd0, 1'b0, 1'b0, 4'd0);
        cyc(LW, 6'd0, 1'b0, 1'b1, 4'd0);
        run_seq(LW, 6'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4);
        run_seq(RT, 6'b101010, 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4);
        run_seq(RT, 6'b100010, 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4);
        run_seq(RT, 6'b100100, 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4);
        run_seq(RT, 6'b000111, 1'b0, 4'd0, 4'd1, 4'd6, 4'd7, 4);
        run_seq(BEQ, 6'd0, 1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 3);
        run_seq(BEQ, 6'd0, 1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 3);
        run_seq(BAD, 6'd0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2);
        run_seq(ADDI, 6'd0, 1'b0, 4'd0, 4'd1, 4'd9, 4'd10, 4);
        run_seq(JMP, 6'd0, 1'b1, 4'd0, 4'd1, 4'd11, 4'd0, 3);
`ifdef MIPS_CTRL_LOGIC_IMM_EN
        run_seq(ANDI, 6'd0, 1'b0, 4'd0, 4'd1, 4'd12, 4'd10, 4);
`else
        run_seq(ANDI, 6'd0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 2);
`endif
        run_seq(SW, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd5, 4);
        // sw aborted by reset while in MEMWR.
        run_seq(SW, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd0, 3);
        cyc(SW, 6'd0, 1'b0, 1'b0, 4'd5);
        run_seq(SW, 6'd0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd0, 3);
        @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control unit for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several clock cycles using a Moore FSM. An ALU decoder drives alucontrol. It selects when the sign-extended immediate (from signextend) feeds the ALU through alusrcb, and it gates all architectural writes (PC, IR, register file, memory).

Parameters:
- OP_W, 6, opcode field width.
- FN_W, 6, funct field width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the rising edge of clk; rst==0 resets).
- op  in  6  instr[31:26] from the IR.
- funct  in  6  instr[5:0] from the IR.
- zero  in  1  ALU zero flag.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  IR load enable.
- memwrite  out  1  data memory write enable.
- regwrite  out  1  register file write enable.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback select: 0 = ALUOut, 1 = Data register.
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A.
- alusrcb  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = signext(imm), 11 = signext(imm) shifted left 2.
- pcsrc  out  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation code.
- pcen  out  1  PC load enable; pcen = pcwrite | (branch & zero).
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current FSM state, for debug and verification.

Behaviour:
- Moore FSM, 4-bit state. Outputs are decoded combinationally from the state only. pcen additionally uses zero.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Transitions:
  - FETCH→DECODE.
  - DECODE on op: 100011 (lw) or 101011 (sw) →MEMADR; 000000 (R-type) →RTYPEEX; 000100 (beq) →BEQEX; 001000 (addi) →ADDIEX; 000010 (j) →JEX; any other op →FETCH with illegal_op=1 for that cycle.
  - MEMADR→MEMRD if op is lw, →MEMWR if op is sw.
  - MEMRD→MEMWB. RTYPEEX→RTYPEWB. ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX all →FETCH.
- Output assertions per state (anything not listed is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=add.
  - DECODE: alusrcb=11, aluop=add (computes the branch target).
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=add.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=funct.
  - RTYPEWB: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, branch=1, pcsrc=01, aluop=sub.
  - ADDIWB: regwrite=1.
  - JEX: pcwrite=1, pcsrc=10.
- ALU decoder:
  - add→010, sub→110.
  - For aluop=funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - An unknown funct gives 010 (add) and is not flagged.
- Latency in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal opcode: 2 cycles, then the next fetch.
- Reset:
  - While rst==0, the next state is FETCH.
  - Every write enable (irwrite, memwrite, regwrite, pcen), illegal_op and every select output are forced to 0, overriding the state decode.
  - Asserting reset mid-instruction aborts it; no partial register or memory write occurs in the cycle rst is low.
  - The first cycle after release is FETCH.
- A sw in MEMADR never reaches MEMRD. A beq with zero=0 leaves pcen=0 in BEQEX.

Optional Feature:
- Macro MIPS_CTRL_LOGIC_IMM_EN.
- When defined:
  - Adds states ANDIEX=12 and ORIEX=13, reached from DECODE on op 001100 (andi) and 001101 (ori).
  - These states use alusrca=1 and alusrcb=10, with alucontrol 000 and 001 respectively, then go to ADDIWB.
  - Adds output zeroext (1 bit), asserted in ANDIEX and ORIEX, that tells signextend to zero-fill the upper half.
- When undefined: andi and ori are illegal opcodes, and the zeroext port does not exist.

Decomposition:
- Package mips_ctrl_pkg holds:
  - a statetype enum with the encodings above;
  - opcode and funct localparams;
  - an aluop enum (ADD, SUB, FUNCT);
  - alusrcb and pcsrc encodings.
- Sub-module mips_aludec (aluop, funct → alucontrol) is purely combinational and is instantiated inside the FSM.

Test Plan:
- Hold rst=0 for 2 cycles while op=100011 → all enables are 0 and state_o=0. Release → state_o=0 (FETCH) with irwrite=1 and pcen=1 on the first active edge window.
- op=100011 (lw) → state_o sequence 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; then state 0.
- op=000000 with funct=101010 → state 6 gives alucontrol=111 and alusrca=1; state 7 gives regwrite=1 and regdst=1.
- op=000100 (beq): with zero=1 in state 8 → pcen=1 and pcsrc=01. Repeat with zero=0 → pcen=0. Both cases take 3 cycles.
- op=111111 → state 0,1,0; illegal_op=1 only in the DECODE cycle; no write enable asserted.
- op=101011 (sw): drive rst=0 during state 5 → memwrite=0 in that cycle; after release the next state is FETCH.
